// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with tear-free frame-aligned data load.
// Optional leading-zero blanking is compiled in with `define SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
   parameter int DIGITS = 8,
   parameter int DIV_W  = 15,
   parameter int GUARD  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [4*DIGITS-1:0]         data,
   input  logic [DIGITS-1:0]           dp_mask,
   input  logic                        load,
   output logic [$clog2(DIGITS)-1:0]   which,
   output logic [DIGITS-1:0]           an,
   output logic [7:0]                  seg,
   output logic                        frame_start
);

   localparam int WW = $clog2(DIGITS);

   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [WW-1:0]       which_q, which_d;
   logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic                pend_flag_q, pend_flag_d;
   logic [4*DIGITS-1:0] shad_data_q, shad_data_d;
   logic [DIGITS-1:0]   shad_dp_q, shad_dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_start_q, frame_start_d;

   logic                tick;
   logic                wrap;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b0000_001;
         4'h1:    g = 7'b1001_111;
         4'h2:    g = 7'b0010_010;
         4'h3:    g = 7'b0000_110;
         4'h4:    g = 7'b1001_100;
         4'h5:    g = 7'b0100_100;
         4'h6:    g = 7'b0100_000;
         4'h7:    g = 7'b0001_111;
         4'h8:    g = 7'b0000_000;
         4'h9:    g = 7'b0000_100;
         4'hA:    g = 7'b0001_000;
         4'hB:    g = 7'b1100_000;
         4'hC:    g = 7'b0110_001;
         4'hD:    g = 7'b1000_010;
         4'hE:    g = 7'b0110_000;
         default: g = 7'b0111_000;
      endcase
      return g;
   endfunction

   assign tick = &cnt_q;
   assign wrap = tick && (which_q == WW'(DIGITS - 1));

   always_comb begin
      cnt_d   = cnt_q + DIV_W'(1);
      which_d = which_q;
      if (tick) begin
         which_d = wrap ? '0 : which_q + WW'(1);
      end
   end

   // Shadow only changes at the frame boundary; a load landing on that same
   // tick still wins the pending slot so the newest value is never lost.
   always_comb begin
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      pend_flag_d = pend_flag_q;
      shad_data_d = shad_data_q;
      shad_dp_d   = shad_dp_q;
      if (wrap && pend_flag_q) begin
         shad_data_d = pend_data_q;
         shad_dp_d   = pend_dp_q;
         pend_flag_d = 1'b0;
      end
      if (load) begin
         pend_data_d = data;
         pend_dp_d   = dp_mask;
         pend_flag_d = 1'b1;
      end
   end

   // Digit 0 shows the most significant nibble.
   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (which_q == WW'(i)) begin
            cur_nib = shad_data_q[4*(DIGITS-1-i) +: 4];
            cur_dp  = shad_dp_q[i];
         end
      end
   end

`ifdef SEG_LZ_BLANK_EN
   logic zero_run;

   always_comb begin
      zero_run  = 1'b1;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         zero_run = zero_run && (shad_data_q[4*(DIGITS-1-i) +: 4] == 4'h0);
         if ((which_q == WW'(i)) && (i != DIGITS - 1)) begin
            cur_blank = zero_run;
         end
      end
   end
`else
   assign cur_blank = 1'b0;
`endif

   always_comb begin
      seg_d         = {(cur_blank ? 7'h7F : glyph(cur_nib)), ~cur_dp};
      frame_start_d = wrap;
      an_d          = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((cnt_q >= DIV_W'(GUARD)) && (which_q == WW'(i))) begin
            an_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         which_q       <= '0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_flag_q   <= 1'b0;
         shad_data_q   <= '0;
         shad_dp_q     <= '0;
         an_q          <= '1;
         seg_q         <= 8'hFF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         which_q       <= which_d;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_flag_q   <= pend_flag_d;
         shad_data_q   <= shad_data_d;
         shad_dp_q     <= shad_dp_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign which       = which_q;
   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl: an 8-digit and a 6-digit
// instance, both with 16-cycle slots and a 3-cycle guard.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [31:0] data;
   logic [7:0]  dp_mask;
   logic [2:0]  which8;
   logic [7:0]  an8;
   logic [7:0]  seg8;
   logic        fs8;

   logic        load6;
   logic [23:0] data6;
   logic [5:0]  dp6;
   logic [2:0]  which6;
   logic [5:0]  an6;
   logic [7:0]  seg6;
   logic        fs6;

   int compared   = 0;
   int mismatched = 0;
   int now_k      = 0;

   logic [7:0] zero_d0;
   logic [7:0] scan_glyph [8];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIGITS(8), .DIV_W(4), .GUARD(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask), .load(load),
      .which(which8), .an(an8), .seg(seg8), .frame_start(fs8)
   );

   seg_scan_ctrl #(.DIGITS(6), .DIV_W(4), .GUARD(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .data(data6), .dp_mask(dp6), .load(load6),
      .which(which6), .an(an6), .seg(seg6), .frame_start(fs6)
   );

   // now_k counts posedges since the last reset release; we sit on the negedge after edge now_k.
   task automatic advance(input int n);
      repeat (n) @(negedge clk);
      now_k += n;
   endtask

   task automatic go_to(input int k);
      if (k > now_k) advance(k - now_k);
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load  = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      now_k = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      compared++;
      if (an8 !== 8'hFF) begin mismatched++; $display("FAIL reset_an got %h want ff", an8); end
      compared++;
      if (seg8 !== 8'hFF) begin mismatched++; $display("FAIL reset_seg got %h want ff", seg8); end
      compared++;
      if (which8 !== 3'd0) begin mismatched++; $display("FAIL reset_which got %0d want 0", which8); end
      compared++;
      if (fs8 !== 1'b0) begin mismatched++; $display("FAIL reset_fs got %b want 0", fs8); end
      rst_n = 1'b1;
      now_k = 0;
      go_to(3);
      compared++;
      if (an8 !== 8'hFF) begin mismatched++; $display("FAIL reset_guard_an got %h want ff", an8); end
      go_to(4);
      compared++;
      if (an8 !== 8'hFE) begin mismatched++; $display("FAIL reset_first_an got %h want fe", an8); end
      compared++;
      if (seg8 !== zero_d0) begin mismatched++; $display("FAIL reset_first_seg got %b want %b", seg8, zero_d0); end
   endtask

   task automatic test_scan_order();
      int hits;
      int first;
      int d;
      hits  = 0;
      first = -1;
      go_to(5);
      data    = 32'h0123_4567;
      dp_mask = 8'h00;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      for (int k = 7; k <= 256; k++) begin
         go_to(k);
         if (fs8 === 1'b1) begin
            hits++;
            if (first < 0) first = k;
         end
         if (k == 130) begin
            compared++;
            if (an8 !== 8'hFF) begin mismatched++; $display("FAIL scan_guard_an got %h want ff", an8); end
         end
         if (k >= 137 && k <= 249 && ((k - 137) % 16) == 0) begin
            d = (k - 137) / 16;
            compared++;
            if (seg8 !== scan_glyph[d]) begin
               mismatched++;
               $display("FAIL scan_seg d%0d got %b want %b", d, seg8, scan_glyph[d]);
            end
            compared++;
            if (an8 !== (8'hFF ^ (8'h01 << d))) begin
               mismatched++;
               $display("FAIL scan_an d%0d got %h want %h", d, an8, 8'hFF ^ (8'h01 << d));
            end
            compared++;
            if (which8 !== 3'(d)) begin
               mismatched++;
               $display("FAIL scan_which d%0d got %0d want %0d", d, which8, d);
            end
         end
      end
      compared++;
      if (hits != 2 || first != 128) begin
         mismatched++;
         $display("FAIL scan_frame_start got hits=%0d first=%0d want hits=2 first=128", hits, first);
      end
   endtask

   task automatic test_tear_free();
      go_to(300);
      data    = 32'hFFFF_FFFF;
      dp_mask = 8'h00;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      go_to(345);
      compared++;
      if (seg8 !== 8'b0100_1001) begin mismatched++; $display("FAIL tear_old_d5 got %b want 01001001", seg8); end
      go_to(377);
      compared++;
      if (seg8 !== 8'b0001_1111) begin mismatched++; $display("FAIL tear_old_d7 got %b want 00011111", seg8); end
      go_to(393);
      compared++;
      if (seg8 !== 8'b0111_0001) begin mismatched++; $display("FAIL tear_new_d0 got %b want 01110001", seg8); end
      compared++;
      if (which8 !== 3'd0) begin mismatched++; $display("FAIL tear_which got %0d want 0", which8); end
      go_to(441);
      compared++;
      if (seg8 !== 8'b0111_0001) begin mismatched++; $display("FAIL tear_new_d3 got %b want 01110001", seg8); end
   endtask

   task automatic test_back_to_back();
      go_to(450);
      data    = 32'h8888_8888;
      dp_mask = 8'h00;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      go_to(511);
      data    = 32'h1111_1111;
      dp_mask = 8'hFF;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      go_to(553);
      compared++;
      if (seg8 !== 8'b0000_0001) begin mismatched++; $display("FAIL b2b_old_pending_d2 got %b want 00000001", seg8); end
      go_to(601);
      compared++;
      if (seg8 !== 8'b0000_0001) begin mismatched++; $display("FAIL b2b_hold_d5 got %b want 00000001", seg8); end
      go_to(745);
      compared++;
      if (seg8 !== 8'b1001_1110) begin mismatched++; $display("FAIL b2b_new_d6 got %b want 10011110", seg8); end
   endtask

   task automatic test_reset_mid_frame();
      go_to(760);
      data    = 32'h2222_2222;
      dp_mask = 8'h00;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      go_to(770);
      rst_n = 1'b0;
      #1;
      compared++;
      if (an8 !== 8'hFF || seg8 !== 8'hFF) begin
         mismatched++;
         $display("FAIL midreset_async got an=%h seg=%h want an=ff seg=ff", an8, seg8);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      now_k = 0;
      go_to(4);
      compared++;
      if (an8 !== 8'hFE) begin mismatched++; $display("FAIL midreset_an got %h want fe", an8); end
      go_to(15);
      compared++;
      if (which8 !== 3'd0) begin mismatched++; $display("FAIL midreset_full_slot got %0d want 0", which8); end
      go_to(16);
      compared++;
      if (which8 !== 3'd1) begin mismatched++; $display("FAIL midreset_next_slot got %0d want 1", which8); end
      go_to(137);
      compared++;
      if (seg8 !== zero_d0) begin mismatched++; $display("FAIL midreset_discard got %b want %b", seg8, zero_d0); end
   endtask

   task automatic test_non_pow2();
      int bad;
      int fs_at;
      int w;
      logic [5:0] exp_an;
      bad   = 0;
      fs_at = -1;
      hold_reset();
      for (int k = 1; k <= 112; k++) begin
         go_to(k);
         w      = ((k - 1) / 16) % 6;
         exp_an = (((k - 1) % 16) >= 3) ? (6'h3F ^ (6'h01 << w)) : 6'h3F;
         if (an6 !== exp_an) begin
            if (bad == 0) $display("FAIL np2_an k=%0d got %b want %b", k, an6, exp_an);
            bad++;
         end
         if (fs6 === 1'b1 && fs_at < 0) fs_at = k;
         if ((k % 16) == 8) begin
            compared++;
            if (which6 !== 3'((k / 16) % 6)) begin
               mismatched++;
               $display("FAIL np2_which k=%0d got %0d want %0d", k, which6, (k / 16) % 6);
            end
         end
         if (k == 88) begin
            compared++;
            if (seg6 !== 8'b0000_0011) begin mismatched++; $display("FAIL np2_seg_d5 got %b want 00000011", seg6); end
         end
      end
      compared++;
      if (bad != 0) begin mismatched++; $display("FAIL np2_an_total got %0d bad cycles want 0", bad); end
      compared++;
      if (fs_at != 96) begin mismatched++; $display("FAIL np2_frame_start got k=%0d want 96", fs_at); end
   endtask

`ifdef SEG_LZ_BLANK_EN
   task automatic test_lz_blank();
      logic [7:0] exp_lz [8];
      exp_lz = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'b0001_0001, 8'b0000_0011, 8'b0100_1000};
      hold_reset();
      go_to(5);
      data    = 32'h0000_0A05;
      dp_mask = 8'h80;
      load    = 1'b1;
      advance(1);
      load = 1'b0;
      for (int d = 0; d < 8; d++) begin
         go_to(137 + 16 * d);
         compared++;
         if (seg8 !== exp_lz[d]) begin
            mismatched++;
            $display("FAIL lz_seg d%0d got %b want %b", d, seg8, exp_lz[d]);
         end
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      data    = 32'h0;
      dp_mask = 8'h0;
      load6   = 1'b0;
      data6   = 24'h0;
      dp6     = 6'h0;
`ifdef SEG_LZ_BLANK_EN
      zero_d0 = 8'hFF;
`else
      zero_d0 = 8'b0000_0011;
`endif
      scan_glyph = '{zero_d0, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                     8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111};
      test_reset();
      test_scan_order();
      test_tear_free();
      test_back_to_back();
      test_reset_mid_frame();
      test_non_pow2();
`ifdef SEG_LZ_BLANK_EN
      test_lz_blank();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
